mult_seq: RTL
=============

MULT_SEQ -- requirements
Module: mult_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 64, operand and result width in bits.
REQ-002 SHALL have clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have start  input  1  request a multiply; sampled at a clk edge only in IDLE.
REQ-005 SHALL have flush  input  1  synchronous abort from pipeline flush.
REQ-006 SHALL have a  input  WIDTH  multiplicand (Rn), sampled with start.
REQ-007 SHALL have b  input  WIDTH  multiplier (Rm), sampled with start.
REQ-008 SHALL have busy  output  1  high when state is not IDLE.
REQ-009 SHALL have stall  output  1  pipeline hold request, combinational.
REQ-010 SHALL have done  output  1  one-cycle completion pulse, registered.
REQ-011 SHALL have result  output  WIDTH  low WIDTH bits of the last completed a*b.

Function
REQ-012 SHALL implement the states IDLE, RUN and DONE with a radix-2 shift-add datapath (acc, mcand, mplier, count registers).
REQ-013 IDLE, start=1, flush=0 at an edge SHALL load acc=0, mcand=a, mplier=b, count=0; the next state SHALL be DONE if b==0, else RUN.
REQ-014 Each RUN edge SHALL perform one iteration: if mplier[0] then acc+=mcand (mod 2^WIDTH); mcand<<=1; mplier>>=1; count+=1.
REQ-015 RUN SHALL go to DONE on the edge whose shifted mplier is 0 or whose count reaches WIDTH-1; otherwise it SHALL stay in RUN.
REQ-016 The number of RUN iterations SHALL be N = msb_index(b)+1, with N=0 for b=0 and a maximum of WIDTH.
REQ-017 done SHALL be high exactly for the DONE cycle, which is N edges after the start edge.
REQ-018 DONE SHALL go to IDLE unconditionally on the next edge; a back-to-back start SHALL be accepted in the following IDLE cycle.
REQ-019 result SHALL update to the final acc only on the edge entering DONE, and SHALL hold that value until the next completion.
REQ-020 Overflow bits above WIDTH-1 SHALL be discarded; no flag SHALL be produced.
REQ-021 stall SHALL equal (IDLE & start & ~flush) | RUN; stall SHALL be low in DONE and in IDLE without start.
REQ-022 start in RUN or DONE SHALL be ignored (not queued).
REQ-023 flush=1 in RUN or DONE SHALL force IDLE at the next edge, suppress done, and leave result unchanged.
REQ-024 flush=1 together with start in IDLE SHALL win, and no load SHALL occur.
REQ-025 a and b changing after the start edge SHALL NOT affect the operation in progress.

Reset
REQ-026 reset_n low SHALL immediately force state=IDLE and acc, mcand, mplier, count and result to 0, and busy and done to 0, regardless of clk.
REQ-027 stall SHALL be held 0 while reset_n is low.
REQ-028 Reset asserted mid-RUN SHALL abort the operation with no done pulse; after release, the block SHALL accept start on the first edge.

Verification
REQ-029 a=3, b=5, start for 1 cycle -> 3 RUN cycles with stall high for 4 cycles (start cycle plus 3 RUN), done pulses 3 edges after start, result=15, busy low after DONE.
REQ-030 a=0x1234, b=0 -> DONE directly after the start edge, done high in that next cycle, result=0, no RUN cycles.
REQ-031 a=1, b=0x8000_0000_0000_0000 -> 64 RUN iterations, done 64 edges after start, result=0x8000_0000_0000_0000; a=0xFFFF_FFFF_FFFF_FFFF, b=2 -> result=0xFFFF_FFFF_FFFF_FFFE.
REQ-032 With result=15 from a prior operation, start a=7, b=0xFF, then flush at the 2nd RUN edge -> IDLE at the next edge, no done, result stays 15, busy=0.
REQ-033 start held high through RUN and DONE -> a single operation, then a new load in the following IDLE cycle; start+flush in IDLE -> stays IDLE, stall=0.
REQ-034 reset_n pulsed low between clk edges mid-RUN -> busy, done, stall and result read 0 immediately; after release, a=2, b=3 yields result=6.

Source files
------------

// File: rtl/mult_seq.sv
// Sequential radix-2 shift-add multiplier: one multiplier bit per RUN cycle,
// early exit once the remaining multiplier bits are all zero.
module mult_seq #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] acc_step;
  logic [WIDTH-1:0] mplier_shift;

  function automatic logic [WIDTH-1:0] shift_add(input logic [WIDTH-1:0] acc,
                                                 input logic [WIDTH-1:0] mcand,
                                                 input logic             bit0);
    return bit0 ? (acc + mcand) : acc;
  endfunction

  assign acc_step     = shift_add(acc_q, mcand_q, mplier_q[0]);
  assign mplier_shift = mplier_q >> 1;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        // flush alongside start wins: no operand load at all
        if (start && !flush) begin
          acc_d    = '0;
          mcand_d  = a;
          mplier_d = b;
          count_d  = '0;
          if (b == '0) begin
            state_d  = DONE;
            done_d   = 1'b1;
            result_d = '0;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          acc_d    = acc_step;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_shift;
          count_d  = count_q + CW'(1);
          if (mplier_shift == '0 || count_q == CW'(WIDTH - 1)) begin
            state_d  = DONE;
            done_d   = 1'b1;
            result_d = acc_step;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  // stall is gated by reset_n so a start held during reset cannot leak out
  assign stall  = reset_n & (((state_q == IDLE) & start & ~flush) | (state_q == RUN));
  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule
